// File: rtl/band_sum_pipe.sv
// band_sum_pipe: per-band gain and enable, registered adder tree, saturating output.
// Latency T+2 cycles (T = ceil(log2 N_BANDS)), one sample set per cycle, no backpressure.
// Optional macro BAND_SUM_SAT_CNT_EN adds a 16-bit saturating clip counter port sat_count.
// GAIN_FRAC must be at least 1.
module band_sum_pipe #(
   parameter int unsigned N_BANDS   = 8,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned GAIN_W    = 8,
   parameter int unsigned GAIN_FRAC = 6,
   parameter int unsigned OUT_W     = 19
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [N_BANDS*DATA_W-1:0]   data_in,
   input  logic [N_BANDS-1:0]          band_en,
   input  logic                        gain_load,
   input  logic [N_BANDS*GAIN_W-1:0]   gain_in,
   input  logic                        sat_clr,
   output logic                        out_valid,
   output logic signed [OUT_W-1:0]     data_out,
   output logic                        sat_flag,
   output logic                        sat_sticky
`ifdef BAND_SUM_SAT_CNT_EN
   ,
   output logic [15:0]                 sat_count
`endif
);

   localparam int unsigned T      = $clog2(N_BANDS);
   localparam int unsigned LEAVES = 1 << T;
   localparam int unsigned P_W    = DATA_W + GAIN_W + 1;
   localparam int unsigned SUM_W  = DATA_W + GAIN_W - GAIN_FRAC + T + 1;
   localparam int unsigned CMP_W  = (SUM_W > OUT_W) ? SUM_W : OUT_W;

   localparam logic signed [GAIN_W-1:0] UNITY = GAIN_W'(1 << GAIN_FRAC);
   localparam logic signed [P_W-1:0]    RND   = P_W'(1 << (GAIN_FRAC - 1));
   localparam logic signed [CMP_W-1:0]  MAX_V = CMP_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [CMP_W-1:0]  MIN_V = CMP_W'(-(64'sd1 <<< (OUT_W - 1)));

   logic [N_BANDS*GAIN_W-1:0]  shadow_q;
   logic [N_BANDS*GAIN_W-1:0]  active_q;
   logic                       pending_q;
   logic                       apply_c;
   logic [N_BANDS*GAIN_W-1:0]  shadow_c;
   logic [N_BANDS*GAIN_W-1:0]  gain_c;

   logic signed [SUM_W-1:0]    leaf_c [N_BANDS];
   logic signed [SUM_W-1:0]    node_q [1:2*LEAVES-1];
   logic [T:0]                 vld_q;

   logic signed [CMP_W-1:0]    root_c;
   logic signed [OUT_W-1:0]    clamp_c;
   logic                       clip_c;

   // Scale one band: full-precision product, round half toward +inf, drop fraction bits
   function automatic logic signed [SUM_W-1:0] scale(input logic signed [DATA_W-1:0] d,
                                                      input logic signed [GAIN_W-1:0] g);
      logic signed [P_W-1:0] p;
      p = P_W'(d) * P_W'(g) + RND;
      return SUM_W'(p >>> GAIN_FRAC);
   endfunction

   // Gain selection: a load coincident with a valid sample lands in shadow and applies at once
   always_comb begin
      apply_c  = in_valid & (pending_q | gain_load);
      shadow_c = gain_load ? gain_in : shadow_q;
      gain_c   = apply_c ? shadow_c : active_q;
   end

   // Shadow/active gain registers; active only changes on a sample boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q  <= {N_BANDS{UNITY}};
         active_q  <= {N_BANDS{UNITY}};
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_c;
         if (apply_c) active_q <= shadow_c;
         pending_q <= apply_c ? 1'b0 : (pending_q | gain_load);
      end
   end

   // Stage 1 combinational leaves: gained, rounded, masked band values
   always_comb begin
      for (int k = 0; k < int'(N_BANDS); k++) begin
         leaf_c[k] = '0;
         if (in_valid && band_en[k])
            leaf_c[k] = scale(data_in[k*DATA_W +: DATA_W], gain_c[k*GAIN_W +: GAIN_W]);
      end
   end

   // Heap-ordered adder tree: leaves at LEAVES.., each parent registers its children's sum
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 1; n < int'(2*LEAVES); n++) node_q[n] <= '0;
         vld_q <= '0;
      end else begin
         vld_q <= {vld_q[T-1:0], in_valid};
         for (int n = 1; n < int'(LEAVES); n++)
            node_q[n] <= node_q[2*n] + node_q[2*n+1];
         for (int i = 0; i < int'(N_BANDS); i++)
            node_q[int'(LEAVES) + i] <= leaf_c[i];
         for (int i = int'(N_BANDS); i < int'(LEAVES); i++)
            node_q[int'(LEAVES) + i] <= '0;
      end
   end

   // Clamp the root sum into the output range
   always_comb begin
      root_c  = CMP_W'(node_q[1]);
      clip_c  = 1'b0;
      clamp_c = OUT_W'(root_c);
      if (root_c > MAX_V) begin
         clamp_c = OUT_W'(MAX_V);
         clip_c  = vld_q[T];
      end else if (root_c < MIN_V) begin
         clamp_c = OUT_W'(MIN_V);
         clip_c  = vld_q[T];
      end
   end

   // Output register: data holds across bubbles, sticky set wins over clear
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         data_out   <= '0;
         sat_flag   <= 1'b0;
         sat_sticky <= 1'b0;
      end else begin
         out_valid  <= vld_q[T];
         sat_flag   <= clip_c;
         if (vld_q[T]) data_out <= clamp_c;
         sat_sticky <= clip_c | (sat_sticky & ~sat_clr);
      end
   end

`ifdef BAND_SUM_SAT_CNT_EN
   // Saturating clip counter; a clip coincident with sat_clr restarts the count at 1
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_count <= '0;
      end else if (clip_c) begin
         if (sat_clr)                    sat_count <= 16'd1;
         else if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      end else if (sat_clr) begin
         sat_count <= '0;
      end
   end
`endif

endmodule

// File: doc/band_sum_pipe.md
Name: band_sum_pipe

Overview:
Parametrised successor of the 8-band recombination adder at the equaliser output. Applies a per-band programmable gain and enable mask, then sums N_BANDS signed band outputs through a registered adder tree. Saturates the result to OUT_W with valid-qualified streaming and overflow reporting. Sits between the band-filter bank and the output DAC/serialiser interface.

Parameters:
N_BANDS, 8, number of bands summed; legal range 2..16, non-power-of-2 allowed.
DATA_W, 16, signed width of each band sample.
GAIN_W, 8, signed width of each band gain.
GAIN_FRAC, 6, fractional bits of gain; unity = 2^GAIN_FRAC = 64.
OUT_W, 19, signed output width; result saturates to this range.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  data_in holds a valid sample set this cycle
data_in  in  N_BANDS*DATA_W  packed band samples; band k at [k*DATA_W +: DATA_W]
band_en  in  N_BANDS  per-band enable; 0 forces band contribution to 0
gain_load  in  1  one-cycle pulse; latch gain_in into shadow register
gain_in  in  N_BANDS*GAIN_W  packed signed gains, band k at [k*GAIN_W +: GAIN_W]
sat_clr  in  1  clears sat_sticky (and sat_count if compiled)
out_valid  out  1  data_out valid
data_out  out  OUT_W  saturated signed sum
sat_flag  out  1  data_out in this cycle was clipped (qualified by out_valid)
sat_sticky  out  1  set on any clip, held until sat_clr or rst

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, data_out=0, sat_flag=0, sat_sticky=0, all pipeline valids and data cleared. Active gains reset to unity (64) for every band; shadow gains to unity; pending flag cleared. Reset mid-stream discards all in-flight samples; no output valid until new in_valid after rst falls.
- Gain update: gain_load writes shadow register and sets pending. Active gains take shadow values on the first cycle with in_valid=1 and pending=1, and apply to that same sample set. Pending then clears. gain_load coincident with that in_valid: the new gain_in is loaded to shadow and applies to that sample, i.e. load-then-apply. Gains never change mid-sample-set.
- Stage 1 (gain): per band p = data*gain, full DATA_W+GAIN_W precision. Then r = (p + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC, rounding half toward +inf. Bands with band_en=0 give 0. band_en is sampled with in_valid.
- Stages 2..1+T, where T = ceil(log2 N_BANDS): registered binary adder tree, one level per stage. Missing leaves are zero-padded. Internal width SUM_W = DATA_W+GAIN_W-GAIN_FRAC+T+1; no internal overflow is possible.
- Final stage: clamp the SUM_W sum to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register it. sat_flag=1 if clamped.
- Latency: fixed L = T+2 cycles from in_valid to out_valid; L=5 for N_BANDS=8. Valid bit shifts alongside data. Throughput is one sample set per cycle; no backpressure. Bubbles are preserved.
- When out_valid=0, data_out holds its last value and sat_flag=0.
- sat_sticky: set when out_valid & sat_flag. sat_clr coincident with a new clip leaves it set (set wins).

Optional Feature:
Macro BAND_SUM_SAT_CNT_EN. When defined, adds output port sat_count (16 bits). It increments on each out_valid & sat_flag and saturates at 0xFFFF, no wrap. Reset and sat_clr clear it; a clip coincident with sat_clr gives 1. When not defined, the port and counter are absent and all other behaviour is identical.

Test Plan:
- Defaults, unity gains, all bands 1000, band_en=0xFF, single in_valid -> out_valid exactly 5 cycles later, data_out=8000, sat_flag=0.
- All bands 32767, unity -> data_out=262136, no clip. All bands -32768 -> data_out=-262144, no clip.
- gain_load with all gains 127, then all bands 32767 -> data_out=262143, sat_flag=1, sat_sticky=1. Then sat_clr -> sticky 0. With macro: sat_count=1, then 0 after clr.
- Back-to-back valids with new gain_load between sample k and k+1 (band0=100, gain 32 = 0.5) -> sample k uses unity, k+1 band0 contributes 50. Rounding check: band0=1, gain 32 -> 1 (0.5 rounds up); band0=-1 -> 0.
- band_en=0x01, band0=-5, others 30000 -> data_out=-5. Also pulse rst while 3 samples are in flight -> no out_valid follows; outputs 0 next cycle.
- N_BANDS=5 override, all bands 10 -> data_out=50 at latency T+2=5. Pattern valid,gap,valid -> same gap at output.
